// File: rtl/uart_host_ctrl.sv
// Wishbone master that configures a 16550-style UART and then services it by polling LSR:
// received bytes are strobed out, and a one-byte holding register feeds the transmitter.
module uart_host_ctrl #(
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0]  LCR_CFG = 8'h03,
  parameter logic [7:0]  FCR_CFG = 8'h07
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic [4:0]  wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        init_done_o,
  output logic        bus_err_o
);

  typedef enum logic [2:0] {
    LCR_DLAB, DLL, DLM, LCR, FCR, POLL, RX_RD, TX_WR
  } state_t;

  state_t      state;
  logic        tx_full;
  logic [7:0]  tx_byte;
  logic [7:0]  rd_byte;

  function automatic logic [4:0] reg_adr(input state_t s);
    case (s)
      LCR_DLAB, LCR:      return 5'd3;
      DLL, RX_RD, TX_WR:  return 5'd0;
      DLM:                return 5'd1;
      FCR:                return 5'd2;
      default:            return 5'd5;
    endcase
  endfunction

  function automatic logic reg_we(input state_t s);
    return !(s == POLL || s == RX_RD);
  endfunction

  function automatic logic [7:0] reg_wdata(input state_t s, input logic [7:0] held);
    case (s)
      LCR_DLAB: return 8'h80 | LCR_CFG;
      DLL:      return DIVISOR[7:0];
      DLM:      return DIVISOR[15:8];
      LCR:      return LCR_CFG;
      FCR:      return FCR_CFG;
      TX_WR:    return held;
      default:  return 8'h00;
    endcase
  endfunction

  // Byte lanes are big-endian within the 32-bit word: offset k%4 == 0 lives in bits [31:24].
  function automatic logic [3:0] lane_sel(input logic [4:0] adr);
    return 4'b1000 >> adr[1:0];
  endfunction

  function automatic logic [31:0] lane_put(input logic [4:0] adr, input logic [7:0] b);
    return {b, 24'h000000} >> {adr[1:0], 3'b000};
  endfunction

  function automatic logic [7:0] lane_get(input logic [4:0] adr, input logic [31:0] d);
    logic [31:0] w;
    w = d << {adr[1:0], 3'b000};
    return w[31:24];
  endfunction

  assign rd_byte = lane_get(wbm_adr_o, wbm_dat_i);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= LCR_DLAB;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= 5'd0;
      wbm_sel_o   <= 4'd0;
      wbm_dat_o   <= 32'd0;
      tx_ready_o  <= 1'b0;
      tx_full     <= 1'b0;
      tx_byte     <= 8'h00;
      rx_valid_o  <= 1'b0;
      rx_data_o   <= 8'h00;
      init_done_o <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;

      if (tx_valid_i && tx_ready_o) begin
        tx_full    <= 1'b1;
        tx_byte    <= tx_data_i;
        tx_ready_o <= 1'b0;
      end else begin
        tx_ready_o <= !tx_full;
      end

      // An idle bus always sits for one cycle before the current state's access is launched.
      if (!wbm_cyc_o) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= reg_we(state);
        wbm_adr_o <= reg_adr(state);
        wbm_sel_o <= lane_sel(reg_adr(state));
        wbm_dat_o <= reg_we(state) ? lane_put(reg_adr(state), reg_wdata(state, tx_byte)) : 32'd0;
      end else if (wbm_ack_i || wbm_err_i) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
        wbm_adr_o <= 5'd0;
        wbm_sel_o <= 4'd0;
        wbm_dat_o <= 32'd0;
        if (wbm_err_i) begin
          // Errored access: state is kept so the same access is retried after the idle cycle.
          bus_err_o <= 1'b1;
        end else begin
          case (state)
            LCR_DLAB: state <= DLL;
            DLL:      state <= DLM;
            DLM:      state <= LCR;
            LCR:      state <= FCR;
            FCR: begin
              state       <= POLL;
              init_done_o <= 1'b1;
            end
            POLL: begin
              if (rd_byte[0])
                state <= RX_RD;
              else if (rd_byte[5] && tx_full)
                state <= TX_WR;
              else
                state <= POLL;
            end
            RX_RD: begin
              rx_data_o  <= rd_byte;
              rx_valid_o <= 1'b1;
              state      <= POLL;
            end
            TX_WR: begin
              tx_full    <= 1'b0;
              tx_ready_o <= 1'b1;
              state      <= POLL;
            end
            default:  state <= LCR_DLAB;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/uart_host_ctrl.md
UART_HOST_CTRL -- requirements
Module: uart_host_ctrl

Interface
REQ-001 SHALL have parameter DIVISOR, default 16'd27, 16-bit baud divisor written to DLL/DLM.
REQ-002 SHALL have parameter LCR_CFG, default 8'h03, line control value (8N1).
REQ-003 SHALL have parameter FCR_CFG, default 8'h07, FIFO control value (enable, clear both FIFOs).
REQ-004 wb_clk_i  in  1  clock; all logic on rising edge.
REQ-005 wb_rst_i  in  1  synchronous, active-high reset.
REQ-006 wbm_adr_o  out  5  byte address of the UART register.
REQ-007 wbm_dat_o  out  32  write data.
REQ-008 wbm_dat_i  in  32  read data.
REQ-009 wbm_sel_o  out  4  byte-lane select.
REQ-010 wbm_we_o, wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone master controls.
REQ-011 wbm_ack_i, wbm_err_i  in  1 each  Wishbone termination.
REQ-012 tx_data_i  in  8  byte to send; tx_valid_i  in  1; tx_ready_o  out  1.
REQ-013 rx_data_o  out  8  received byte; rx_valid_o  out  1  one-cycle strobe.
REQ-014 init_done_o  out  1  high once UART configuration is complete.
REQ-015 bus_err_o  out  1  sticky; set on any wbm_err_i.

Function
REQ-016 Register at byte offset k SHALL use wbm_sel_o = 4'b1000 >> k, data on bits [31-8k:24-8k] (big-endian lanes), wbm_adr_o = k; other lanes 0.
REQ-017 Each access SHALL assert cyc/stb/we/adr/sel/dat together and hold them stable until ack or err; all deassert the cycle after termination; there SHALL be at least one idle cycle between accesses.
REQ-018 FSM states: LCR_DLAB, DLL, DLM, LCR, FCR, POLL, RX_RD, TX_WR.
REQ-019 Init sequence SHALL be: write 8'h80|LCR_CFG to offset 3; DIVISOR[7:0] to 0; DIVISOR[15:8] to 1; LCR_CFG to 3; FCR_CFG to 2; then POLL; each state advances only on termination.
REQ-020 init_done_o SHALL go high the cycle after the FCR write terminates and stay high until reset.
REQ-021 POLL SHALL read offset 5 (LSR); on termination with LSR[0]=1 go to RX_RD; else if LSR[5]=1 and holding register full go to TX_WR; else re-issue POLL.
REQ-022 RX_RD SHALL read offset 0; on ack, rx_data_o = lane byte and rx_valid_o = 1 for exactly the following cycle; return to POLL.
REQ-023 RX has priority over TX when both LSR[0] and LSR[5] are set; TX is served on the next poll.
REQ-024 One-byte TX holding register: tx_ready_o = 1 when empty; byte captured when tx_valid_i & tx_ready_o; tx_ready_o SHALL be low the cycle after capture.
REQ-025 Capture SHALL be allowed during init; the byte is held until TX_WR.
REQ-026 TX_WR SHALL write held byte to offset 0; holding register empties on ack (tx_ready_o = 1 next cycle); return to POLL.
REQ-027 On wbm_err_i: set bus_err_o, end cycle, retry the same state's access; data from an errored read SHALL be discarded; holding register not emptied.
REQ-028 rx_valid_o SHALL have no backpressure; consumer must accept every strobe.

Reset
REQ-029 On wb_rst_i: state=LCR_DLAB, cyc/stb/we=0, adr=0, sel=0, dat_o=0, tx_ready_o=0 during reset then 1, holding register empty, rx_valid_o=0, rx_data_o=0, init_done_o=0, bus_err_o=0.
REQ-030 Reset asserted mid-access SHALL drop cyc/stb next cycle and discard the pending access and held byte; a late ack after reset SHALL be ignored.

Verification
REQ-031 Reset release, slave acks after 2 cycles -> writes (3,80/83 for default),(0,1B),(1,00),(3,03),(2,07) in order, init_done_o=1, then LSR reads at adr 5, sel 4'b0000_0100 pattern 4'b0100.
REQ-032 tx_data_i=8'h41 pulse during init, LSR=8'h60 -> single write adr 0, sel 4'b1000, dat 32'h4100_0000; tx_ready_o returns 1 after ack.
REQ-033 LSR=8'h61, RBR=8'h5A -> read adr 0 precedes TX write; rx_data_o=8'h5A with one-cycle rx_valid_o.
REQ-034 LSR=8'h00 for 10 polls with byte held -> no TX write, tx_ready_o stays 0, stb held until ack each time.
REQ-035 wbm_err_i on the DLM write -> bus_err_o=1, DLM write retried, init completes.
REQ-036 wb_rst_i asserted while TX_WR stb waiting -> cyc/stb low next cycle, sequence restarts at LCR_DLAB, held byte lost.
